// File: rtl/ce_gen_pkg.sv
// Shared constants and elaboration helpers for the clock-enable generator bank.
package ce_gen_pkg;

   localparam int unsigned F_CLK_DEF   = 50_000_000;
   localparam int unsigned F_BASE_DEF  = 1_000_000;
   localparam int unsigned DIV_RST_DEF = 10;

   // Terminal value of the base prescaler down-counter.
   function automatic int unsigned pre_calc(input int unsigned f_clk, input int unsigned f_base);
      return f_clk / f_base - 1;
   endfunction

   function automatic bit ratio_ok(input int unsigned f_clk, input int unsigned f_base);
      return (f_base != 0) && (f_clk % f_base == 0) && (f_clk / f_base >= 2);
   endfunction

endpackage

// File: rtl/ce_gen_bank_chan.sv
// One channel: down-counter with terminal-count enable, active divisor and a
// shadow divisor that is committed only at a wrap or a phase restart.
module ce_chan
   import ce_gen_pkg::*;
#(
   parameter int unsigned CW      = 16,
   parameter int unsigned DIV_RST = DIV_RST_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          src,
   input  logic          sync,
   input  logic          wr,
   input  logic [CW-1:0] wr_div,
   output logic          ce,
   output logic          pend
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] div_q;
   logic [CW-1:0] shd;
   logic [CW-1:0] eff_div;
   logic [CW-1:0] reload;
   logic          silent;
   logic          wrap;

   // A write landing in the commit cycle takes precedence over the shadow.
   always_comb begin
      eff_div = div_q;
      if (pend) eff_div = shd;
      if (wr)   eff_div = wr_div;
      reload = (eff_div == '0) ? '0 : eff_div - CW'(1);
   end

   assign silent = (div_q == '0);
   assign wrap   = src & (cnt == '0) & ~silent;
   assign ce     = wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= CW'(DIV_RST - 1);
         div_q <= CW'(DIV_RST);
         shd   <= '0;
         pend  <= 1'b0;
      end else if (silent && wr) begin
         // Nothing to keep glitch-free on a silent channel, so apply at once.
         div_q <= wr_div;
         cnt   <= reload;
         pend  <= 1'b0;
      end else if (sync || wrap) begin
         div_q <= eff_div;
         cnt   <= reload;
         pend  <= 1'b0;
      end else begin
         if (src && cnt != '0) cnt <= cnt - CW'(1);
         if (wr) begin
            shd  <= wr_div;
            pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ce_gen_bank.sv
// Multi-channel clock-enable generator: base prescaler plus NCH divider channels.
// Define CE_GEN_CASCADE_EN to chain channel k onto the enable of channel k-1.
module ce_gen_bank
   import ce_gen_pkg::*;
#(
   parameter int unsigned F_CLK   = F_CLK_DEF,
   parameter int unsigned F_BASE  = F_BASE_DEF,
   parameter int unsigned NCH     = 4,
   parameter int unsigned CW      = 16,
   parameter int unsigned DIV_RST = DIV_RST_DEF
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     en,
   input  logic                                     sync,
   input  logic                                     cfg_we,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
   input  logic [CW-1:0]                            cfg_div,
   output logic                                     ce_base,
   output logic [NCH-1:0]                           ce,
   output logic [NCH-1:0]                           pend
);

   localparam int unsigned PRE = pre_calc(F_CLK, F_BASE);
   localparam int          PW  = (PRE < 2) ? 1 : $clog2(PRE + 1);
   localparam int          CHW = (NCH > 1) ? $clog2(NCH) : 1;

   if (!ratio_ok(F_CLK, F_BASE)) begin : g_bad_ratio
      $error("ce_gen_bank: F_CLK/F_BASE must be an integer >= 2");
   end

   logic [PW-1:0] pre_cnt;
   logic          sync_en;

   // A stalled bank keeps its phase, so restart is honoured only while enabled.
   assign sync_en = sync & en;

   always_ff @(posedge clk) begin
      if (rst)          pre_cnt <= PW'(PRE);
      else if (sync_en) pre_cnt <= PW'(PRE);
      else if (en)      pre_cnt <= (pre_cnt == '0) ? PW'(PRE) : pre_cnt - PW'(1);
   end

   assign ce_base = en & ~rst & ~sync & (pre_cnt == '0);

   for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
      logic src_k;
      logic ce_k;
      logic wr_k;

`ifdef CE_GEN_CASCADE_EN
      if (k == 0) begin : g_src
         assign src_k = ce_base;
      end else begin : g_src
         assign src_k = g_ch[k-1].ce_k;
      end
`else
      assign src_k = ce_base;
`endif

      assign wr_k  = cfg_we & (cfg_ch == CHW'(k));
      assign ce[k] = ce_k;

      ce_chan #(
         .CW      (CW),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .src    (src_k),
         .sync   (sync_en),
         .wr     (wr_k),
         .wr_div (cfg_div),
         .ce     (ce_k),
         .pend   (pend[k])
      );
   end

endmodule

// File: tb/tb_ce_gen_bank.sv
// Self-checking bench for ce_gen_bank: probe table plus event scoreboard.
module tb_ce_gen_bank;

   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int CHW = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           sync = 1'b0;
   logic           cfg_we = 1'b0;
   logic [CHW-1:0] cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           ce_base;
   logic [NCH-1:0] ce;
   logic [NCH-1:0] pend;

   always #5 clk = ~clk;

   ce_gen_bank #(
      .F_CLK   (50000000),
      .F_BASE  (1000000),
      .NCH     (NCH),
      .CW      (CW),
      .DIV_RST (10)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .ce_base (ce_base),
      .ce      (ce),
      .pend    (pend)
   );

   typedef struct {
      int             cyc;
      logic [NCH-1:0] mask;
   } ev_t;

   typedef struct {
      int             cyc;
      logic           base;
      logic [NCH-1:0] ce;
      logic [NCH-1:0] pend;
   } vec_t;

   ev_t  q_ce[$];
   int   q_base[$];
   vec_t vt[10];
   int   cyc;
   int   nerr = 0;
   int   nchk = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic fail(input string name, input int exp_cyc);
      nchk++;
      nerr++;
      $display("FAIL %s: expected at cycle %0d, now cycle %0d", name, exp_cyc, cyc);
   endtask

   task automatic monitor();
      ev_t e;
      while (q_base.size() > 0 && q_base[0] < cyc) fail("ce_base_missing", q_base.pop_front());
      if (ce_base !== 1'b0) begin
         if (q_base.size() == 0) fail("ce_base_unexpected", -1);
         else chk("ce_base_cycle", cyc, q_base.pop_front());
      end
      while (q_ce.size() > 0 && q_ce[0].cyc < cyc) begin
         e = q_ce.pop_front();
         fail("ce_missing", e.cyc);
      end
      if (ce !== '0) begin
         if (q_ce.size() == 0) fail("ce_unexpected", -1);
         else begin
            e = q_ce.pop_front();
            chk("ce_cycle", cyc, e.cyc);
            chk("ce_mask", ce, e.mask);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      advance();
   endtask

   task automatic tick_vec(input vec_t v);
      @(negedge clk);
      monitor();
      chk("tbl_base", ce_base, v.base);
      chk("tbl_ce", ce, v.ce);
      chk("tbl_pend", pend, v.pend);
      advance();
   endtask

   task automatic tick_pend(input logic [NCH-1:0] exp);
      @(negedge clk);
      monitor();
      chk("pend", pend, exp);
      advance();
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic push_base(input int first, input int last);
      for (int t = first; t <= last; t += 50) q_base.push_back(t);
   endtask

   task automatic push_ce(input int t, input logic [NCH-1:0] m);
      ev_t e;
      e.cyc  = t;
      e.mask = m;
      q_ce.push_back(e);
   endtask

   task automatic write(input int ch, input int dv);
      cfg_we  = 1'b1;
      cfg_ch  = CHW'(ch);
      cfg_div = CW'(dv);
   endtask

   task automatic finish_scn();
      ev_t e;
      while (q_base.size() > 0) fail("ce_base_missing", q_base.pop_front());
      while (q_ce.size() > 0) begin
         e = q_ce.pop_front();
         fail("ce_missing", e.cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b1;
      sync = 1'b0;
      cfg_we = 1'b0;
      q_ce.delete();
      q_base.delete();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ce", ce, 0);
      chk("rst_ce_base", ce_base, 0);
      chk("rst_pend", pend, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      vt = '{'{0,   1'b0, 4'h0, 4'h0}, '{48,  1'b0, 4'h0, 4'h0},
             '{49,  1'b1, 4'h0, 4'h0}, '{50,  1'b0, 4'h0, 4'h0},
             '{98,  1'b0, 4'h0, 4'h0}, '{99,  1'b1, 4'h0, 4'h0},
             '{498, 1'b0, 4'h0, 4'h0}, '{499, 1'b1, 4'hF, 4'h0},
             '{500, 1'b0, 4'h0, 4'h0}, '{999, 1'b1, 4'hF, 4'h0}};

`ifdef CE_GEN_CASCADE_EN
      // Chained periods: 10 base ticks, then x10 per stage.
      do_reset();
      push_base(49, 50009);
      for (int t = 499; t <= 50009; t += 500) begin
         logic [NCH-1:0] m;
         m = 4'b0001;
         if ((t + 1) % 5000 == 0)  m = m | 4'b0010;
         if ((t + 1) % 50000 == 0) m = m | 4'b0100;
         push_ce(t, m);
      end
      run_to(50010);
      finish_scn();
`else
      // Free running after reset, with a probe table.
      do_reset();
      push_base(49, 1009);
      push_ce(499, 4'hF);
      push_ce(999, 4'hF);
      for (int i = 0; i < 10; i++) begin
         run_to(vt[i].cyc);
         tick_vec(vt[i]);
      end
      run_to(1010);
      finish_scn();

      // Shadow divisor committed at the next wrap.
      do_reset();
      push_base(49, 1009);
      push_ce(499, 4'hF);
      push_ce(649, 4'h1);
      push_ce(799, 4'h1);
      push_ce(949, 4'h1);
      push_ce(999, 4'hE);
      run_to(100);
      write(0, 3);
      tick_pend(4'h0);
      cfg_we = 1'b0;
      tick_pend(4'h1);
      run_to(499);
      tick_pend(4'h1);
      tick_pend(4'h0);
      run_to(1010);
      finish_scn();

      // Silence a channel, then revive it at divisor 1.
      do_reset();
      push_base(49, 1009);
      push_ce(499, 4'hF);
      for (int t = 749; t <= 949; t += 50) push_ce(t, 4'h2);
      push_ce(999, 4'hF);
      run_to(100);
      write(1, 0);
      tick();
      cfg_we = 1'b0;
      tick_pend(4'h2);
      run_to(700);
      write(1, 1);
      tick_pend(4'h0);
      cfg_we = 1'b0;
      tick_pend(4'h0);
      run_to(1010);
      finish_scn();

      // Phase restart with merged write, last-write-wins and write-at-wrap.
      do_reset();
      push_base(49, 299);
      push_base(350, 1009);
      push_ce(400, 4'h4);
      push_ce(500, 4'h4);
      push_ce(600, 4'h4);
      push_ce(700, 4'h4);
      push_ce(800, 4'hF);
      push_ce(900, 4'h5);
      push_ce(1000, 4'hD);
      run_to(300);
      sync = 1'b1;
      write(2, 2);
      tick();
      sync = 1'b0;
      cfg_we = 1'b0;
      tick_pend(4'h0);
      run_to(320);
      write(3, 5);
      tick();
      cfg_we = 1'b0;
      run_to(330);
      write(3, 4);
      tick();
      cfg_we = 1'b0;
      tick_pend(4'h8);
      run_to(800);
      write(0, 2);
      tick();
      cfg_we = 1'b0;
      tick_pend(4'h0);
      run_to(1010);
      finish_scn();
`endif

      // Enable gap, then reset exactly on a tick cycle.
      do_reset();
      for (int t = 69; t <= 969; t += 50) q_base.push_back(t);
      push_ce(519, 4'hF);
      run_to(40);
      en = 1'b0;
      run_to(60);
      en = 1'b1;
      run_to(1000);
      write(0, 7);
      tick();
      cfg_we = 1'b0;
      tick_pend(4'h1);
      run_to(1019);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
      finish_scn();
      push_base(49, 609);
      push_ce(499, 4'hF);
      tick_pend(4'h0);
      run_to(610);
      finish_scn();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
